// File: rtl/pmem_responder.sv
// Memory-side responder between the EXU data port and the simulated physical
// memory. pmem_pkg holds the simulated memory, standing in for the DPI-C backed
// pmem_read/pmem_write. Each call is logged so that accesses can be observed.
package pmem_pkg;

   logic [7:0]  mem [int unsigned];
   int unsigned read_count  = 0;
   int unsigned write_count = 0;
   logic [31:0] last_waddr  = '0;
   logic [31:0] last_wlen   = '0;
   logic [31:0] last_wdata  = '0;

   // Returns the raw aligned word containing addr; unwritten bytes read as 0.
   function automatic logic [31:0] pmem_read(input logic [31:0] addr);
      logic [31:0] base;
      logic [31:0] word;
      base = {addr[31:2], 2'b00};
      word = '0;
      read_count++;
      for (int unsigned i = 0; i < 4; i++) begin
         if (mem.exists(base + i)) word[8*i +: 8] = mem[base + i];
      end
      return word;
   endfunction

   // Stores the low len bytes of data starting at addr.
   function automatic void pmem_write(input logic [31:0] addr, input logic [31:0] len,
                                      input logic [31:0] data);
      write_count++;
      last_waddr = addr;
      last_wlen  = len;
      last_wdata = data;
      for (int unsigned i = 0; i < 4; i++) begin
         if (i < len) mem[addr + i] = data[8*i +: 8];
      end
   endfunction

endpackage

// Single-outstanding load/store responder with programmable latency.
module pmem_responder #(
   parameter int unsigned LATENCY = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_wen,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [1:0]  req_size,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic        resp_wen
);
   import pmem_pkg::*;

   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_t;

   localparam logic [7:0] CNT_INIT = (LATENCY == 0) ? 8'd0 : 8'(LATENCY - 1);

   state_t      state_q;
   logic [7:0]  cnt_q;
   logic        wen_q;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic [1:0]  size_q;
   logic        err_q;
   logic        resp_valid_q;
   logic [31:0] resp_rdata_q;
   logic        resp_err_q;
   logic        resp_wen_q;
   logic        illegal_d;

   // Performs the memory access for a legal request; stores and errors yield 0.
   function automatic logic [31:0] do_access(input logic wen, input logic [31:0] addr,
                                             input logic [31:0] wdata, input logic [1:0] size,
                                             input logic err);
      logic [31:0] r;
      r = '0;
      if (!err) begin
         if (wen) pmem_write(addr, 32'd1 << size, wdata);
         else     r = pmem_read(addr);
      end
      return r;
   endfunction

   // Size/alignment legality of the request currently presented.
   always_comb begin
      illegal_d = 1'b0;
      case (req_size)
         2'd1:    illegal_d = req_addr[0];
         2'd2:    illegal_d = (req_addr[1:0] != 2'b00);
         2'd3:    illegal_d = 1'b1;
         default: illegal_d = 1'b0;
      endcase
   end

   assign req_ready  = (state_q == S_IDLE);
   assign resp_valid = resp_valid_q;
   assign resp_rdata = resp_rdata_q;
   assign resp_err   = resp_err_q;
   assign resp_wen   = resp_wen_q;

   // Request/latency/response FSM; the access happens on the edge entering RESP.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         cnt_q        <= '0;
         wen_q        <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         size_q       <= '0;
         err_q        <= 1'b0;
         resp_valid_q <= 1'b0;
         resp_rdata_q <= '0;
         resp_err_q   <= 1'b0;
         resp_wen_q   <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (req_valid) begin
                  wen_q   <= req_wen;
                  addr_q  <= req_addr;
                  wdata_q <= req_wdata;
                  size_q  <= req_size;
                  err_q   <= illegal_d;
                  if (LATENCY == 0) begin
                     resp_rdata_q <= do_access(req_wen, req_addr, req_wdata, req_size, illegal_d);
                     resp_valid_q <= 1'b1;
                     resp_err_q   <= illegal_d;
                     resp_wen_q   <= req_wen;
                     state_q      <= S_RESP;
                  end else begin
                     cnt_q   <= CNT_INIT;
                     state_q <= S_BUSY;
                  end
               end
            end
            S_BUSY: begin
               if (cnt_q != 8'd0) begin
                  cnt_q <= cnt_q - 8'd1;
               end else begin
                  resp_rdata_q <= do_access(wen_q, addr_q, wdata_q, size_q, err_q);
                  resp_valid_q <= 1'b1;
                  resp_err_q   <= err_q;
                  resp_wen_q   <= wen_q;
                  state_q      <= S_RESP;
               end
            end
            S_RESP: begin
               if (resp_ready) begin
                  resp_valid_q <= 1'b0;
                  resp_rdata_q <= '0;
                  resp_err_q   <= 1'b0;
                  resp_wen_q   <= 1'b0;
                  state_q      <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_pmem_responder.sv
// Directed bench for pmem_responder: four instances with LATENCY 1, 3, 0, 4
// sharing the simulated memory in pmem_pkg.
module tb_pmem_responder;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid_a  [4];
   logic        req_ready_a  [4];
   logic        req_wen_a    [4];
   logic [31:0] req_addr_a   [4];
   logic [31:0] req_wdata_a  [4];
   logic [1:0]  req_size_a   [4];
   logic        resp_valid_a [4];
   logic        resp_ready_a [4];
   logic [31:0] resp_rdata_a [4];
   logic        resp_err_a   [4];
   logic        resp_wen_a   [4];

   int unsigned checks = 0;
   int unsigned errors = 0;
   int unsigned cycle  = 0;
   int unsigned last_accept [4];
   int unsigned last_gap = 0;

   always #5 clk = ~clk;

   // Free-running cycle count used to measure acceptance spacing.
   always @(posedge clk) cycle <= cycle + 1;

   for (genvar g = 0; g < 4; g++) begin : g_dut
      pmem_responder #(
         .LATENCY((g == 0) ? 1 : (g == 1) ? 3 : (g == 2) ? 0 : 4)
      ) u_dut (
         .clk        (clk),
         .rst        (rst),
         .req_valid  (req_valid_a[g]),
         .req_ready  (req_ready_a[g]),
         .req_wen    (req_wen_a[g]),
         .req_addr   (req_addr_a[g]),
         .req_wdata  (req_wdata_a[g]),
         .req_size   (req_size_a[g]),
         .resp_valid (resp_valid_a[g]),
         .resp_ready (resp_ready_a[g]),
         .resp_rdata (resp_rdata_a[g]),
         .resp_err   (resp_err_a[g]),
         .resp_wen   (resp_wen_a[g])
      );
   end

   function automatic int unsigned lat_of(input int k);
      case (k)
         0:       return 1;
         1:       return 3;
         2:       return 0;
         default: return 4;
      endcase
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
      end
   endtask

   task automatic preload(input logic [31:0] addr, input logic [31:0] data);
      for (int unsigned i = 0; i < 4; i++) pmem_pkg::mem[addr + i] = data[8*i +: 8];
   endtask

   // One full transaction on instance k; hold = extra RESP cycles with resp_ready low.
   task automatic run(input int k, input logic wen, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [1:0] size,
                      input logic [31:0] exp_rdata, input int unsigned hold, input string tag);
      logic        legal;
      int unsigned r0, w0, cyc;
      logic [31:0] snap;
      legal = !((size == 2'd3) || (size == 2'd1 && addr[0]) ||
                (size == 2'd2 && addr[1:0] != 2'b00));
      r0 = pmem_pkg::read_count;
      w0 = pmem_pkg::write_count;
      chk({tag, ":ready_idle"}, 32'(req_ready_a[k]), 32'd1);
      req_valid_a[k] = 1'b1;
      req_wen_a[k]   = wen;
      req_addr_a[k]  = addr;
      req_wdata_a[k] = wdata;
      req_size_a[k]  = size;
      tick();
      last_gap       = cycle - last_accept[k];
      last_accept[k] = cycle;
      req_valid_a[k] = 1'b0;
      req_wen_a[k]   = ~wen;
      req_addr_a[k]  = 32'hFFFF_FFFF;
      req_wdata_a[k] = 32'h5555_5555;
      req_size_a[k]  = 2'd3;
      cyc = 0;
      while (!resp_valid_a[k] && cyc < 300) begin
         chk({tag, ":early_calls"}, (pmem_pkg::read_count - r0) + (pmem_pkg::write_count - w0), 32'd0);
         tick();
         cyc++;
      end
      chk({tag, ":latency"}, cyc, lat_of(k));
      chk({tag, ":rdata"}, resp_rdata_a[k], exp_rdata);
      chk({tag, ":err"}, 32'(resp_err_a[k]), 32'(!legal));
      chk({tag, ":wen"}, 32'(resp_wen_a[k]), 32'(wen));
      chk({tag, ":ready_resp"}, 32'(req_ready_a[k]), 32'd0);
      chk({tag, ":reads"}, pmem_pkg::read_count - r0, 32'(legal && !wen));
      chk({tag, ":writes"}, pmem_pkg::write_count - w0, 32'(legal && wen));
      if (legal && wen) begin
         chk({tag, ":waddr"}, pmem_pkg::last_waddr, addr);
         chk({tag, ":wlen"}, pmem_pkg::last_wlen, 32'd1 << size);
         chk({tag, ":wdata"}, pmem_pkg::last_wdata, wdata);
      end
      snap = resp_rdata_a[k];
      for (int unsigned i = 0; i < hold; i++) begin
         tick();
         chk({tag, ":hold_valid"}, 32'(resp_valid_a[k]), 32'd1);
         chk({tag, ":hold_rdata"}, resp_rdata_a[k], snap);
         chk({tag, ":hold_ready"}, 32'(req_ready_a[k]), 32'd0);
         chk({tag, ":hold_calls"}, (pmem_pkg::read_count - r0) + (pmem_pkg::write_count - w0),
             32'(legal));
      end
      resp_ready_a[k] = 1'b1;
      tick();
      chk({tag, ":done_valid"}, 32'(resp_valid_a[k]), 32'd0);
      chk({tag, ":done_rdata"}, resp_rdata_a[k], 32'd0);
      chk({tag, ":done_ready"}, 32'(req_ready_a[k]), 32'd1);
      if (k != 2) resp_ready_a[k] = 1'b0;
   endtask

   initial begin
      int unsigned w0;
      for (int k = 0; k < 4; k++) begin
         req_valid_a[k]  = 1'b0;
         req_wen_a[k]    = 1'b0;
         req_addr_a[k]   = '0;
         req_wdata_a[k]  = '0;
         req_size_a[k]   = '0;
         resp_ready_a[k] = (k == 2);
         last_accept[k]  = 0;
      end
      tick();
      tick();
      rst = 1'b0;

      for (int k = 0; k < 4; k++) begin
         chk("rst_ready", 32'(req_ready_a[k]), 32'd1);
         chk("rst_valid", 32'(resp_valid_a[k]), 32'd0);
         chk("rst_rdata", resp_rdata_a[k], 32'd0);
         chk("rst_errwen", {30'd0, resp_err_a[k], resp_wen_a[k]}, 32'd0);
      end

      preload(32'h8000_0000, 32'hDEAD_BEEF);
      run(0, 1'b0, 32'h8000_0000, 32'h0, 2'd2, 32'hDEAD_BEEF, 0, "t1_load_word");

      run(1, 1'b1, 32'h8000_0103, 32'h0000_00A5, 2'd0, 32'h0, 0, "t2_store_byte");
      run(1, 1'b0, 32'h8000_0100, 32'h0, 2'd2, 32'hA500_0000, 0, "t2_readback");

      run(0, 1'b0, 32'h8000_0001, 32'h0, 2'd1, 32'h0, 0, "t3_half_mis");
      run(0, 1'b0, 32'h8000_0002, 32'h0, 2'd2, 32'h0, 0, "t3_word_mis");
      run(0, 1'b0, 32'h8000_0000, 32'h0, 2'd3, 32'h0, 0, "t3_size3_ld");
      run(1, 1'b1, 32'h8000_0000, 32'h1234_5678, 2'd3, 32'h0, 0, "t3_size3_st");
      run(0, 1'b1, 32'h8000_0106, 32'h0000_BBBB, 2'd1, 32'h0, 0, "t3_half_ok");
      run(0, 1'b0, 32'h8000_0104, 32'h0, 2'd2, 32'hBBBB_0000, 0, "t3_half_rb");

      run(0, 1'b0, 32'h8000_0000, 32'h0, 2'd2, 32'hDEAD_BEEF, 10, "t4_backpressure");

      for (int i = 0; i < 4; i++) begin
         run(2, 1'b1, 32'h8000_0000 + 32'(4 * i), 32'h1111_1111 * 32'(i + 1), 2'd2, 32'h0, 0,
             "t5_store");
         if (i > 0) chk("t5_gap", last_gap, 32'd2);
      end
      for (int i = 0; i < 4; i++)
         run(2, 1'b0, 32'h8000_0000 + 32'(4 * i), 32'h0, 2'd2, 32'h1111_1111 * 32'(i + 1), 0,
             "t5_readback");

      preload(32'h8000_0200, 32'hCAFE_F00D);
      w0 = pmem_pkg::write_count;
      req_valid_a[3] = 1'b1;
      req_wen_a[3]   = 1'b1;
      req_addr_a[3]  = 32'h8000_0200;
      req_wdata_a[3] = 32'h1234_5678;
      req_size_a[3]  = 2'd2;
      tick();
      req_valid_a[3] = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("t6_ready", 32'(req_ready_a[3]), 32'd1);
      chk("t6_valid", 32'(resp_valid_a[3]), 32'd0);
      chk("t6_rdata", resp_rdata_a[3], 32'd0);
      for (int i = 0; i < 6; i++) tick();
      chk("t6_no_write", pmem_pkg::write_count - w0, 32'd0);
      chk("t6_ready_idle", 32'(req_ready_a[3]), 32'd1);
      run(3, 1'b0, 32'h8000_0200, 32'h0, 2'd2, 32'hCAFE_F00D, 0, "t6_old_value");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pmem_responder.md
Name: pmem_responder

Overview:
- Memory-side responder for load/store traffic from the LSU.
- Accepts one request at a time on a valid/ready request channel and waits a programmable latency.
- Performs exactly one pmem_read or pmem_write DPI call per accepted legal request, then returns the result on a valid/ready response channel.
- Sits between the EXU data-memory port and the DPI-backed simulated physical memory.

Parameters:
LATENCY, 1, number of rising edges from request acceptance to response valid (0 allowed; valid range 0..255)

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  synchronous, active-high reset
req_valid  input  1  request present
req_ready  output  1  responder can accept a request this cycle
req_wen  input  1  1 = store, 0 = load
req_addr  input  32  byte address
req_wdata  input  32  store data, passed unmodified to pmem_write
req_size  input  2  0 = byte, 1 = half, 2 = word, 3 = illegal
resp_valid  output  1  response present
resp_ready  input  1  initiator accepts response
resp_rdata  output  32  raw word from pmem_read for loads; 0 for stores and errors
resp_err  output  1  request was illegal; no memory access performed
resp_wen  output  1  echo of req_wen for the transaction

Behaviour:
- Reset: synchronous, active-high, clocked on clk. On reset, state=IDLE, counter=0, resp_valid=0, resp_rdata=0, resp_err=0, resp_wen=0. req_ready=1 in the first cycle after reset deasserts.
- States:
  - IDLE: req_ready=1, resp_valid=0.
  - BUSY: req_ready=0, resp_valid=0.
  - RESP: req_ready=0, resp_valid=1.
- req_ready is a pure function of the state (IDLE), with no combinational path from req_valid.
- Acceptance is the rising edge with req_valid && req_ready; call it edge 0. req_wen, req_addr, req_wdata and req_size are latched at edge 0. Request inputs are don't-care outside IDLE.
- Legality check at acceptance:
  - Illegal if req_size==3, or size==1 with addr[0]!=0, or size==2 with addr[1:0]!=0.
  - An illegal request makes no DPI call and sets resp_err=1 and resp_rdata=0; latency timing is unchanged.
- Latency:
  - LATENCY==0: the access is performed at edge 0; IDLE->RESP.
  - LATENCY>0: counter is loaded with LATENCY-1 and the state goes IDLE->BUSY. In BUSY, counter!=0 decrements; counter==0 performs the access and goes BUSY->RESP.
  - Either way, resp_valid is high in the cycle after edge LATENCY.
- Access:
  - Load calls pmem_read(addr) once; the returned 32-bit value goes unmodified into resp_rdata. Extension and lane selection belong to the initiator.
  - Store calls pmem_write(addr, 1<<size, wdata) once; resp_rdata=0.
  - The DPI call happens exactly once, on the edge that enters RESP.
- Response handshake:
  - In RESP, all resp_* outputs are held stable until resp_valid && resp_ready at a rising edge. That edge moves to IDLE and clears resp_valid, resp_rdata, resp_err and resp_wen to 0.
  - No new request is accepted in the same edge, so back-to-back throughput is one transaction per LATENCY+2 cycles.
- Backpressure: resp_ready low holds RESP indefinitely, with no further DPI calls.
- Reset mid-operation:
  - Reset in BUSY abandons the transaction; no DPI call is made.
  - Reset in RESP discards the pending response; the access already happened.
  - Reset has priority over every other event on the same edge.
- Counter is 8 bits wide and never wraps: it stops at 0 and only reloads on acceptance.
- resp_ready asserted while not in RESP is ignored.

Test Plan:
1. LATENCY=1, load word: pmem[0x80000000]=0xDEADBEEF; req (wen=0, addr=0x80000000, size=2) accepted at edge 0 -> resp_valid high after edge 1, resp_rdata=0xDEADBEEF, resp_err=0; exactly 1 pmem_read call.
2. LATENCY=3, store byte (addr=0x80000103, wdata=0x000000A5, size=0) -> pmem_write(0x80000103, 1, 0xA5) called once at edge 3; resp_valid after edge 3, resp_rdata=0, resp_wen=1; a following load of 0x80000100 returns byte 3 = 0xA5.
3. Misaligned: load half at 0x80000001, then word at 0x80000002, then size=3 -> each gives resp_err=1, resp_rdata=0, zero DPI calls, same latency as a legal request.
4. Backpressure: resp_ready=0 for 10 cycles in RESP -> resp_valid/resp_rdata stable, req_ready=0, DPI call count unchanged; resp_ready=1 -> IDLE next edge, req_ready=1 the following cycle.
5. LATENCY=0 with resp_ready tied high, 4 consecutive word stores to 0x80000000..0x8000000C -> one accept every 2 cycles, 4 pmem_write calls in order, a readback returns all 4 words.
6. LATENCY=4, rst asserted at edge 2 after accepting a store -> no pmem_write call; outputs reset; req_ready=1 the cycle after rst drops; the next load returns the old memory value.
